// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage and its EX consumer: opcodes,
// instruction field positions, the NOP/bubble opcode and the FSM encoding.
package id_stage_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;

    typedef struct packed {
        logic wen;
        logic memrd;
        logic memwr;
        logic branch;
    } ctrl_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_LSTALL = 1'b1
    } id_state_e;

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder: controls, source-use flags, second read
// address select (rd for stores) and sign-extended imm4.
module id_decode
    import id_stage_pkg::*;
#(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4,
    parameter int ISIZE = 16
) (
    input  logic [ISIZE-1:0] insn,
    output logic [3:0]       op,
    output ctrl_t            ctrl,
    output logic             use_a,
    output logic             use_b,
    output logic [ASIZE-1:0] rd,
    output logic [ASIZE-1:0] raddr1,
    output logic [ASIZE-1:0] raddr2,
    output logic [DSIZE-1:0] imm
);

    logic [3:0] op_f;

    always_comb begin
        op_f   = insn[OP_LSB +: 4];
        rd     = insn[RD_LSB +: ASIZE];
        raddr1 = insn[RS1_LSB +: ASIZE];
        raddr2 = insn[RS2_LSB +: ASIZE];
        imm    = {{(DSIZE-4){insn[RS2_LSB+3]}}, insn[RS2_LSB +: 4]};
        op     = op_f;
        ctrl   = '0;
        use_a  = 1'b0;
        use_b  = 1'b0;
        case (op_f)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                ctrl.wen = 1'b1;
                use_a    = 1'b1;
                use_b    = 1'b1;
            end
            OP_ADDI: begin
                ctrl.wen = 1'b1;
                use_a    = 1'b1;
            end
            OP_LW: begin
                ctrl.wen   = 1'b1;
                ctrl.memrd = 1'b1;
                use_a      = 1'b1;
            end
            OP_SW: begin
                // Store data comes from rd, so it rides the second read port.
                ctrl.memwr = 1'b1;
                use_a      = 1'b1;
                use_b      = 1'b1;
                raddr2     = insn[RD_LSB +: ASIZE];
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                use_a       = 1'b1;
                use_b       = 1'b1;
            end
            default: op = OP_NOP;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: ID/EX pipeline register, load-use interlock, branch flush
// squash, interlock FSM and saturating stall/flush counters.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4,
    parameter int ISIZE = 16,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [ISIZE-1:0] if_insn,
    input  logic             ex_hold,
    input  logic             ex_flush,
    output logic [ASIZE-1:0] raddr1,
    output logic [ASIZE-1:0] raddr2,
    input  logic [DSIZE-1:0] rdata1,
    input  logic [DSIZE-1:0] rdata2,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [3:0]       ex_op,
    output logic [ASIZE-1:0] ex_rd,
    output logic [DSIZE-1:0] ex_a,
    output logic [DSIZE-1:0] ex_b,
    output logic [DSIZE-1:0] ex_imm,
    output logic             ex_wen,
    output logic             ex_memrd,
    output logic             ex_memwr,
    output logic             ex_branch,
    output logic [CNTW-1:0]  stall_cnt,
    output logic [CNTW-1:0]  flush_cnt
);

    logic [3:0]       dec_op;
    ctrl_t            dec_ctrl;
    logic             dec_use_a, dec_use_b;
    logic [ASIZE-1:0] dec_rd;
    logic [DSIZE-1:0] dec_imm;

    id_decode #(.DSIZE(DSIZE), .ASIZE(ASIZE), .ISIZE(ISIZE)) u_decode (
        .insn   (if_insn),
        .op     (dec_op),
        .ctrl   (dec_ctrl),
        .use_a  (dec_use_a),
        .use_b  (dec_use_b),
        .rd     (dec_rd),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .imm    (dec_imm)
    );

    logic             ex_valid_q, ex_valid_d;
    logic [3:0]       ex_op_q, ex_op_d;
    logic [ASIZE-1:0] ex_rd_q, ex_rd_d;
    logic [DSIZE-1:0] ex_a_q, ex_a_d;
    logic [DSIZE-1:0] ex_b_q, ex_b_d;
    logic [DSIZE-1:0] ex_imm_q, ex_imm_d;
    ctrl_t            ex_ctrl_q, ex_ctrl_d;
    id_state_e        state_q, state_d;
    logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0]  flush_cnt_q, flush_cnt_d;
    logic             hazard;
    logic             take_hazard;

    // Hazard depends only on the instruction and ID/EX, never on rdata.
    always_comb begin
        hazard = if_valid && ex_valid_q && ex_ctrl_q.memrd &&
                 ((dec_use_a && ex_rd_q == raddr1) || (dec_use_b && ex_rd_q == raddr2));
        take_hazard = hazard && !ex_flush && !ex_hold;
        id_stall    = !ex_flush && (ex_hold || hazard);
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_rd_d    = ex_rd_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_imm_d   = ex_imm_q;
        ex_ctrl_d  = ex_ctrl_q;
        if (ex_flush || (!ex_hold && (hazard || !if_valid))) begin
            ex_valid_d = 1'b0;
            ex_op_d    = OP_NOP;
            ex_rd_d    = '0;
            ex_a_d     = '0;
            ex_b_d     = '0;
            ex_imm_d   = '0;
            ex_ctrl_d  = '0;
        end else if (!ex_hold) begin
            ex_valid_d = 1'b1;
            ex_op_d    = dec_op;
            ex_rd_d    = dec_rd;
            ex_a_d     = rdata1;
            ex_b_d     = rdata2;
            ex_imm_d   = dec_imm;
            ex_ctrl_d  = dec_ctrl;
        end
    end

    // LSTALL lasts exactly one edge: the bubble it inserted has memrd=0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (take_hazard) state_d = ST_LSTALL;
            ST_LSTALL: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
        if (ex_flush) state_d = ST_RUN;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (take_hazard && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        if (ex_flush && flush_cnt_q != '1)    flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_op_q     <= OP_NOP;
            ex_rd_q     <= '0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_imm_q    <= '0;
            ex_ctrl_q   <= '0;
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_op_q     <= ex_op_d;
            ex_rd_q     <= ex_rd_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            ex_imm_q    <= ex_imm_d;
            ex_ctrl_q   <= ex_ctrl_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    a_no_hazard_in_lstall : assert property (@(posedge clk) disable iff (rst)
        !(state_q == ST_LSTALL && hazard));

    assign ex_valid  = ex_valid_q;
    assign ex_op     = ex_op_q;
    assign ex_rd     = ex_rd_q;
    assign ex_a      = ex_a_q;
    assign ex_b      = ex_b_q;
    assign ex_imm    = ex_imm_q;
    assign ex_wen    = ex_ctrl_q.wen;
    assign ex_memrd  = ex_ctrl_q.memrd;
    assign ex_memwr  = ex_ctrl_q.memwr;
    assign ex_branch = ex_ctrl_q.branch;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
